vga_timing_gen: RTL and testbench

- Generates raster timing for the graphics labs: hsync, vsync, display_on and the pixel coordinates x/y that lab_top consumes to produce red/green/blue.
- Divides the system clock down to a pixel-rate enable and runs horizontal and vertical counters through the active, front-porch, sync and back-porch phases.
- Sits between the board clock/reset and the lab_top video inputs; drives the board VGA sync pins directly.

---
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (sync, display_on, x/y, pixel_tick, frame_start).
// Define VGA_TIMING_FRAME_COUNT_EN to build the completed-frame counter on frame_cnt.
module vga_timing_gen #(
  parameter int clk_mhz       = 50,
  parameter int pixel_mhz     = 25,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int h_front       = 16,
  parameter int h_sync        = 96,
  parameter int h_back        = 48,
  parameter int v_front       = 10,
  parameter int v_sync        = 2,
  parameter int v_back        = 33,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           pixel_tick,
  output logic           frame_start,
  output logic [15:0]    frame_cnt
);
  localparam int clk_div = clk_mhz / pixel_mhz;
  localparam int h_total = screen_width + h_front + h_sync + h_back;
  localparam int v_total = screen_height + v_front + v_sync + v_back;
  localparam int w_d = clk_div > 1 ? $clog2(clk_div) : 1;
  localparam int w_h = $clog2(h_total);
  localparam int w_v = $clog2(v_total);
  if (clk_mhz % pixel_mhz != 0) begin : g_div_check
    $error("vga_timing_gen: clk_mhz must be an integer multiple of pixel_mhz");
  end
  localparam logic [w_d-1:0] d_last = w_d'(clk_div - 1);
  localparam logic [w_h-1:0] h_last = w_h'(h_total - 1);
  localparam logic [w_v-1:0] v_last = w_v'(v_total - 1);
  // Bounds carry one spare bit so a zero back porch cannot overflow them.
  localparam logic [w_h:0] h_act  = (w_h+1)'(screen_width);
  localparam logic [w_h:0] hs_beg = (w_h+1)'(screen_width + h_front);
  localparam logic [w_h:0] hs_end = (w_h+1)'(screen_width + h_front + h_sync);
  localparam logic [w_v:0] v_act  = (w_v+1)'(screen_height);
  localparam logic [w_v:0] vs_beg = (w_v+1)'(screen_height + v_front);
  localparam logic [w_v:0] vs_end = (w_v+1)'(screen_height + v_front + v_sync);
  logic [w_d-1:0] div_cnt;
  logic [w_h-1:0] h_cnt;
  logic [w_v-1:0] v_cnt;
  logic [w_h:0]   hx;
  logic [w_v:0]   vx;
  logic           adv, h_wrap, v_wrap, active;
  always_comb begin
    hx     = {1'b0, h_cnt};
    vx     = {1'b0, v_cnt};
    adv    = div_cnt == d_last;
    h_wrap = adv && h_cnt == h_last;
    v_wrap = h_wrap && v_cnt == v_last;
    active = hx < h_act && vx < v_act;
  end
  always_ff @(posedge clk)
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= adv ? '0 : div_cnt + 1'b1;
      h_cnt   <= h_wrap ? '0 : h_cnt + w_h'(adv);
      v_cnt   <= v_wrap ? '0 : v_cnt + w_v'(h_wrap);
    end
  // Registered decode keeps every output one clk behind the counters and aligned.
  always_ff @(posedge clk)
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b0;
      x           <= '0;
      y           <= '0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !(hx >= hs_beg && hx < hs_end);
      vsync       <= !(vx >= vs_beg && vx < vs_end);
      display_on  <= active;
      x           <= active ? w_x'(h_cnt) : '0;
      y           <= active ? w_y'(v_cnt) : '0;
      pixel_tick  <= div_cnt == '0;
      frame_start <= div_cnt == '0 && h_cnt == '0 && v_cnt == '0;
    end
`ifdef VGA_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clk)
    if (rst) frame_cnt <= '0;
    else if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster geometry.
module tb_vga_timing_gen;
  localparam int DIV = 2;
  localparam int SW = 16, SH = 8, HF = 2, HS = 3, HB = 2, VF = 1, VS = 2, VB = 1;
  localparam int HT = SW + HF + HS + HB;
  localparam int VT = SH + VF + VS + VB;
  localparam int F = DIV * HT * VT;

  typedef struct packed {
    logic hs, vs, de;
    logic [3:0] x;
    logic [2:0] y;
    logic pt, fs;
    logic [15:0] fc;
  } exp_t;

  logic clk = 0, rst = 1;
  logic hsync, vsync, display_on, pixel_tick, frame_start;
  logic [3:0] x;
  logic [2:0] y;
  logic [15:0] frame_cnt;
  logic hsync1, vsync1, display_on1, pixel_tick1, frame_start1;
  logic [3:0] x1;
  logic [2:0] y1;
  logic [15:0] frame_cnt1;
  exp_t obs, e;
  exp_t q[$];
  int checks = 0, fails = 0, k = 0;
  localparam exp_t RST_E = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 4'd0, y: 3'd0, pt: 1'b0, fs: 1'b0, fc: 16'd0};

  always #5 clk = ~clk;

  vga_timing_gen #(.clk_mhz(50), .pixel_mhz(25), .screen_width(SW), .screen_height(SH),
    .h_front(HF), .h_sync(HS), .h_back(HB), .v_front(VF), .v_sync(VS), .v_back(VB)) u0 (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .x(x), .y(y), .pixel_tick(pixel_tick), .frame_start(frame_start), .frame_cnt(frame_cnt));

  vga_timing_gen #(.clk_mhz(25), .pixel_mhz(25), .screen_width(SW), .screen_height(SH),
    .h_front(HF), .h_sync(HS), .h_back(HB), .v_front(VF), .v_sync(VS), .v_back(VB)) u1 (
    .clk(clk), .rst(rst), .hsync(hsync1), .vsync(vsync1), .display_on(display_on1),
    .x(x1), .y(y1), .pixel_tick(pixel_tick1), .frame_start(frame_start1), .frame_cnt(frame_cnt1));

  assign obs = '{hs: hsync, vs: vsync, de: display_on, x: x, y: y,
                 pt: pixel_tick, fs: frame_start, fc: frame_cnt};

  // Expected outputs after the k-th edge since reset release, from absolute time.
  function automatic exp_t model(int t);
    exp_t m;
    int d, p, h, v;
    d = t % DIV;
    p = t / DIV;
    h = p % HT;
    v = (p / HT) % VT;
    m.de = h < SW && v < SH;
    m.x  = m.de ? 4'(h) : 4'd0;
    m.y  = m.de ? 3'(v) : 3'd0;
    m.hs = !(h >= SW + HF && h < SW + HF + HS);
    m.vs = !(v >= SH + VF && v < SH + VF + VS);
    m.pt = d == 0;
    m.fs = d == 0 && h == 0 && v == 0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    m.fc = 16'((t + 1) / F);
`else
    m.fc = 16'd0;
`endif
    return m;
  endfunction

  task automatic restart();
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    k = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== RST_E) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d got %h want %h", i, obs, RST_E);
      end
    end
    rst = 0;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      q.push_back(model(k));
      k++;
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_release k=%0d got %h want %h", k - 1, obs, e);
      end
    end
  endtask

  task automatic test_raster();
    restart();
    for (int i = 0; i < 3 * F + 2; i++) begin
      @(posedge clk);
      q.push_back(model(k));
      k++;
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        if (fails < 20) $display("FAIL raster k=%0d got %h want %h", k - 1, obs, e);
      end
    end
  endtask

  task automatic test_line();
    int hs_low = 0, de_cnt = 0, f0 = -1, f1 = -1;
    logic prev = 1;
    restart();
    for (int t = 0; t < 2 * HT * DIV; t++) begin
      @(negedge clk);
      if (t < HT * DIV && !hsync) hs_low++;
      if (t < HT * DIV && display_on) de_cnt++;
      if (prev && !hsync) begin
        if (f0 < 0) f0 = t;
        else if (f1 < 0) f1 = t;
      end
      prev = hsync;
      if (t == SW * DIV - 1) begin
        checks++;
        if (x !== 4'(SW - 1) || display_on !== 1'b1) begin
          fails++;
          $display("FAIL line_last_pixel x=%0d de=%b want x=%0d de=1", x, display_on, SW - 1);
        end
      end
      if (t == SW * DIV) begin
        checks++;
        if (x !== 4'd0 || display_on !== 1'b0) begin
          fails++;
          $display("FAIL line_blank x=%0d de=%b want x=0 de=0", x, display_on);
        end
      end
    end
    checks++;
    if (hs_low !== HS * DIV) begin
      fails++;
      $display("FAIL hsync_width got %0d want %0d", hs_low, HS * DIV);
    end
    checks++;
    if (f1 - f0 !== HT * DIV) begin
      fails++;
      $display("FAIL hsync_period got %0d want %0d", f1 - f0, HT * DIV);
    end
    checks++;
    if (de_cnt !== SW * DIV) begin
      fails++;
      $display("FAIL display_on_per_line got %0d want %0d", de_cnt, SW * DIV);
    end
  endtask

  task automatic test_frame();
    int fs_t[$];
    int vs_low = 0, vs_first = -1, y_bad = 0;
    restart();
    for (int t = 0; t < 2 * F + 4; t++) begin
      @(negedge clk);
      if (frame_start) fs_t.push_back(t);
      if (t < F && !vsync) begin
        vs_low++;
        if (vs_first < 0) vs_first = t;
      end
      if (display_on && y > 3'(SH - 1)) y_bad++;
    end
    checks++;
    if (fs_t.size() != 3 || fs_t[0] != 0 || fs_t[1] != F || fs_t[2] != 2 * F) begin
      fails++;
      $display("FAIL frame_start_spacing got n=%0d want 3 pulses at 0,%0d,%0d", fs_t.size(), F, 2 * F);
    end
    checks++;
    if (vs_low !== VS * HT * DIV) begin
      fails++;
      $display("FAIL vsync_width got %0d want %0d", vs_low, VS * HT * DIV);
    end
    checks++;
    if (vs_first !== (SH + VF) * HT * DIV) begin
      fails++;
      $display("FAIL vsync_start got %0d want %0d", vs_first, (SH + VF) * HT * DIV);
    end
    checks++;
    if (y_bad !== 0) begin
      fails++;
      $display("FAIL y_in_active got %0d bad samples want 0", y_bad);
    end
  endtask

  task automatic test_mid_reset();
    restart();
    repeat ((5 * HT + 10) * DIV) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== RST_E) begin
        fails++;
        $display("FAIL mid_reset_hold cyc=%0d got %h want %h", i, obs, RST_E);
      end
    end
    rst = 0;
    k = 0;
    for (int i = 0; i < F + 1; i++) begin
      @(posedge clk);
      q.push_back(model(k));
      k++;
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        if (fails < 20) $display("FAIL mid_reset_restart k=%0d got %h want %h", k - 1, obs, e);
      end
    end
  endtask

  task automatic test_div1();
    int pt_low = 0, hs_low = 0, f0 = -1, f1 = -1;
    logic prev = 1;
    restart();
    for (int t = 0; t < 2 * HT; t++) begin
      @(negedge clk);
      if (!pixel_tick1) pt_low++;
      if (t < HT && !hsync1) hs_low++;
      if (prev && !hsync1) begin
        if (f0 < 0) f0 = t;
        else if (f1 < 0) f1 = t;
      end
      prev = hsync1;
      if (t == 5) begin
        checks++;
        if (x1 !== 4'd5) begin
          fails++;
          $display("FAIL div1_x got %0d want 5", x1);
        end
      end
    end
    checks++;
    if (pt_low !== 0) begin
      fails++;
      $display("FAIL div1_pixel_tick got %0d low samples want 0", pt_low);
    end
    checks++;
    if (hs_low !== HS) begin
      fails++;
      $display("FAIL div1_hsync_width got %0d want %0d", hs_low, HS);
    end
    checks++;
    if (f1 - f0 !== HT) begin
      fails++;
      $display("FAIL div1_line got %0d want %0d", f1 - f0, HT);
    end
  endtask

  task automatic test_frame_cnt();
    int n = 0;
    restart();
    for (int t = 0; t < 3 * F + 1; t++) begin
      @(negedge clk);
`ifdef VGA_TIMING_FRAME_COUNT_EN
      if (frame_start) begin
        checks++;
        if (frame_cnt !== 16'(n)) begin
          fails++;
          $display("FAIL frame_cnt at pulse %0d got %0d want %0d", n, frame_cnt, n);
        end
        n++;
      end
`else
      if (frame_cnt !== 16'd0) n++;
`endif
    end
`ifndef VGA_TIMING_FRAME_COUNT_EN
    checks++;
    if (n !== 0) begin
      fails++;
      $display("FAIL frame_cnt_tied got %0d nonzero samples want 0", n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_raster();
    test_line();
    test_frame();
    test_mid_reset();
    test_div1();
    test_frame_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
